tick_timer: RTL
===============

# tick_timer

Consumer-side companion to the slow-clock divider: takes the divider's square-wave output as a plain data signal in the fast `clk_in` domain and converts each edge into a single-cycle tick. Uses those ticks to run a loadable down-count timer with start/abort/done handshaking. The Simon game FSM uses it to time color-display and player-response intervals without clocking any logic from the divided clock.

## Interface
- `WIDTH`, 16: width of `load_value` and `remaining`.
- `BOTH_EDGES`, 0: 0 = tick on rising edges of `slow_clk` only; 1 = tick on both edges.
- `clk_in`  input  1  fast system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `slow_clk`  input  1  divider output; asynchronous to nothing but treated as data and synchronized.
- `start`  input  1  one-cycle request to load `load_value` and begin counting.
- `abort`  input  1  cancel a running count; no `done` produced.
- `load_value`  input  WIDTH  number of ticks to wait; sampled only in a cycle where `start` is accepted.
- `busy`  output  1  high while state is RUN.
- `done`  output  1  one-cycle pulse when the count expires.
- `tick_out`  output  1  registered one-cycle pulse per detected edge, independent of timer state.
- `remaining`  output  WIDTH  ticks left before expiry.

## Operation
- Synchronizer: two flops `s0 -> s1`, then history flop `s_prev`.
  - Rising tick: `s1 & ~s_prev`.
  - Both-edge tick: `s1 ^ s_prev`.
- `tick_out` is the tick registered once.
- States:
  - IDLE: `start` with `load_value != 0` loads `remaining <= load_value` and goes to RUN. `start` with `load_value == 0` goes straight to FINISH with `remaining <= 0`.
  - RUN: on tick, `remaining <= remaining - 1`. A tick when `remaining == 1` sets `remaining <= 0` and goes to FINISH.
  - FINISH: lasts exactly one cycle with `done = 1`, then returns to IDLE. `remaining` holds 0.
- Priority in RUN, highest first:
  1. `abort`: go to IDLE, `remaining <= 0`, no `done`.
  2. `start`: retrigger; reload `load_value`, stay in RUN, ignore a coincident tick. Retrigger with `load_value == 0` goes to FINISH.
  3. tick: decrement as above.
- `abort` in IDLE or FINISH is ignored. The FINISH pulse always completes.
- `start` in FINISH is ignored. The requester must wait for IDLE (`busy == 0` and `done == 0`).
- `remaining` never wraps. Decrement occurs only from values of 1 or more.
- Ticks keep being detected and `tick_out` keeps pulsing in every state. Ticks in IDLE or FINISH do not affect `remaining`.
- Reset (asynchronous, at any time including mid-count):
  - `s0`, `s1`, `s_prev` = 0.
  - State = IDLE.
  - `remaining` = 0, `busy` = 0, `done` = 0, `tick_out` = 0.
  - A `slow_clk` that is already high when reset is released produces one rising tick after synchronization. This is accepted behaviour.

## Timing
- `slow_clk` edge to internal tick: the edge is first sampled into `s0` at `clk_in` edge k. The tick is high in the cycle after edge k+1. `remaining` decrements and `tick_out` rises at edge k+2.
- `start` to `busy`: `start` sampled at edge n gives `busy = 1` and `remaining = load_value` after edge n.
- Last tick to `done`: the last tick is consumed at edge m. FINISH (`done = 1`, `busy = 0`) is in effect after edge m and lasts one cycle. IDLE follows after edge m+1.
- Zero-load `start` at edge n: `done = 1` for the cycle after edge n. `busy` never asserts.
- `abort` at edge n: `busy = 0` after edge n.
- Minimum `slow_clk` high/low time is 2 `clk_in` periods for correct edge detection. The divider provides far more.
- Each tick costs at most one decrement.
- Total expiry time for load value L, rising mode: between L−1 and L full `slow_clk` periods after the `start` edge, plus 3 `clk_in` cycles.

## Test plan
- Basic count:
  - Stimulus: reset, `BOTH_EDGES=0`, `slow_clk` period 8 cycles, `start` with `load_value=3`.
  - Required: `busy` high for 3 rising ticks; `remaining` steps 3→2→1→0; exactly one `done` pulse 3 cycles after the third rising `slow_clk` edge.
- Both-edge mode:
  - Stimulus: `BOTH_EDGES=1`, `load_value=4`.
  - Required: `done` after 2 `slow_clk` periods; `tick_out` pulses 4 times in that window.
- Zero load:
  - Stimulus: `start` with `load_value=0`.
  - Required: `done=1` on the next cycle, `busy` stays 0, `remaining=0`.
- Retrigger and abort:
  - Stimulus: `load_value=5`; after 2 ticks, `start` with `load_value=2` in the same cycle as a tick; later assert `start` and `abort` together.
  - Required: `remaining` becomes 2 with no decrement on the retrigger cycle; on the combined request, go to IDLE, `remaining=0`, no `done`.
- Asynchronous reset mid-count:
  - Stimulus: `load_value=10`, assert `reset` mid-cycle after 4 ticks.
  - Required: all outputs 0 immediately, without waiting for a clock edge; no `done` afterward until a new `start`.
- Ignored requests:
  - Stimulus: `start` during the FINISH cycle; ticks while in IDLE.
  - Required: the `start` has no effect; `remaining` stays 0; `tick_out` still pulses.

Source files
------------

// File: rtl/tick_timer.sv
// tick_timer: edge-detects a synchronized slow clock into ticks and runs a loadable down-count timer on them.
module tick_timer #(
  parameter int WIDTH      = 16,
  parameter bit BOTH_EDGES = 1'b0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] load_value,
  output logic             busy,
  output logic             done,
  output logic             tick_out,
  output logic [WIDTH-1:0] remaining
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic s0_q, s1_q, s_prev_q, tick_out_q, tick;
  logic [WIDTH-1:0] rem_q, rem_d;
  assign tick = BOTH_EDGES ? (s1_q ^ s_prev_q) : (s1_q & ~s_prev_q);
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE:
        if (start) begin
          state_d = (load_value == '0) ? FINISH : RUN;
          rem_d   = load_value;
        end
      RUN:
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (start) begin
          state_d = (load_value == '0) ? FINISH : RUN;
          rem_d   = load_value;
        end else if (tick && rem_q != '0) begin
          state_d = (rem_q == WIDTH'(1)) ? FINISH : RUN;
          rem_d   = rem_q - WIDTH'(1);
        end
      FINISH: begin
        state_d = IDLE;
        rem_d   = '0;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      s_prev_q   <= 1'b0;
      tick_out_q <= 1'b0;
      state_q    <= IDLE;
      rem_q      <= '0;
    end else begin
      s0_q       <= slow_clk;
      s1_q       <= s0_q;
      s_prev_q   <= s1_q;
      tick_out_q <= tick;
      state_q    <= state_d;
      rem_q      <= rem_d;
    end
  assign busy      = state_q == RUN;
  assign done      = state_q == FINISH;
  assign tick_out  = tick_out_q;
  assign remaining = rem_q;
endmodule
